// File: rtl/hdshk_sync_arbiter_pkg.sv
// hsa_pkg: shared state encoding and default
// parameters for the sync arbiter slice.
package hsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } hsa_state_e;

  localparam int HSA_N_REQ       = 4;
  localparam int HSA_CNT_W       = 8;
  localparam int HSA_TIMEOUT_CYC = 64;

endpackage

// File: rtl/hdshk_sync_arbiter_if.sv
// hsa_if: requester, status and synchronizer
// link signals of the sync arbiter.
interface hsa_if
  import hsa_pkg::*;
#(
  parameter int N_REQ = HSA_N_REQ,
  parameter int CNT_W = HSA_CNT_W
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             ovf_clr;
  logic             sync_busy;
  logic             sync_sig_a;
  logic [ID_W-1:0]  tag;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] ovf;
  logic [CNT_W-1:0] launch_cnt;
  logic             tmo_err;

  modport master (
    input  req,
    input  ovf_clr,
    input  sync_busy,
    output sync_sig_a,
    output tag,
    output pend,
    output ovf,
    output launch_cnt,
    output tmo_err
  );

  modport slave (
    output req,
    output ovf_clr,
    output sync_busy,
    input  sync_sig_a,
    input  tag,
    input  pend,
    input  ovf,
    input  launch_cnt,
    input  tmo_err
  );

endinterface

// File: rtl/hdshk_sync_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker,
// searches from ptr+1 upward with wrap.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_vld
);

  int w_pos;

  // farthest offset first so the nearest hit wins
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_pos = (int'(i_ptr) + k) % N_REQ;
      if (i_req[w_pos]) begin
        o_idx = ID_W'(w_pos);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdshk_sync_arbiter.sv
// hdshk_sync_arbiter: shares one pulse synchronizer
// among N_REQ requesters. Option: HSA_TIMEOUT_EN.
module hdshk_sync_arbiter
  import hsa_pkg::*;
#(
  parameter int N_REQ       = HSA_N_REQ,
  parameter int CNT_W       = HSA_CNT_W,
  parameter int TIMEOUT_CYC = HSA_TIMEOUT_CYC
) (
  input  logic  clk_a,
  input  logic  rst_n,
  hsa_if.master bus
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("hdshk_sync_arbiter: bad parameters");
  end

  hsa_state_e       r_state;
  logic             r_sig;
  logic [ID_W-1:0]  r_tag;
  logic [ID_W-1:0]  r_ptr;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0]  w_gidx;
  logic             w_gvld;
  logic             w_launch;
  logic [N_REQ-1:0] w_gvec;
  logic [N_REQ-1:0] w_pend_nx;
  logic [N_REQ-1:0] w_ovf_set;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_idx (w_gidx),
    .o_vld (w_gvld)
  );

  // grant decision and pending/overflow next state
  always_comb begin
    w_launch = (r_state == ST_IDLE) && w_gvld
               && !bus.sync_busy;
    w_gvec = '0;
    if (w_launch) w_gvec[w_gidx] = 1'b1;
    w_ovf_set = bus.req & r_pend & ~w_gvec;
    w_pend_nx = (r_pend & ~w_gvec) | bus.req;
  end

  // latch events; a new event beats a same-cycle grant
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= w_pend_nx;
      r_ovf  <= (bus.ovf_clr ? '0 : r_ovf) | w_ovf_set;
    end
  end

`ifdef HSA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_tmo;
`endif

  // launch FSM walking the synchronizer busy handshake
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sig   <= 1'b0;
      r_tag   <= '0;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_cnt   <= '0;
`ifdef HSA_TIMEOUT_EN
      r_wd    <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_sig <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_sig   <= 1'b1;
            r_tag   <= w_gidx;
            r_ptr   <= w_gidx;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ST_WAIT_BUSY;
`ifdef HSA_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.sync_busy) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!bus.sync_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef HSA_TIMEOUT_EN
      if (r_state != ST_IDLE) begin
        if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          r_tmo   <= 1'b1;
          r_state <= ST_IDLE;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.sync_sig_a = r_sig;
  assign bus.tag        = r_tag;
  assign bus.pend       = r_pend;
  assign bus.ovf        = r_ovf;
  assign bus.launch_cnt = r_cnt;
`ifdef HSA_TIMEOUT_EN
  assign bus.tmo_err    = r_tmo;
`else
  assign bus.tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hdshk_sync_arbiter.sv
// tb_hdshk_sync_arbiter: scoreboard bench with a
// busy-handshake stub for the synchronizer.
module tb_hdshk_sync_arbiter;

  localparam int N        = 4;
  localparam int CW       = 8;
  localparam int BUSY_LEN = 3;

  logic clk_a = 1'b0;
  logic rst_n = 1'b0;

  hsa_if #(.N_REQ(N), .CNT_W(CW)) bus ();

  hdshk_sync_arbiter #(
    .N_REQ       (N),
    .CNT_W       (CW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_a (clk_a),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_a = ~clk_a;

  typedef struct {
    int tag;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   exp_cnt   = 0;
  bit   stub_auto = 1'b1;
  int   busy_cnt  = 0;
  logic prev_sig  = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               name, obs, exp);
    end
  endtask

  task automatic expect_launch(input int tag);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    sb.push_back('{tag, exp_cnt});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_a);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.sync_busy)
           && k < budget) begin
      tick();
      k++;
    end
    check("drain_left", sb.size(), 0);
    tick(2);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.ovf_clr = 1'b0;
    tick(2);
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, "_sig"},  bus.sync_sig_a, 0);
    check({pfx, "_tag"},  bus.tag, 0);
    check({pfx, "_pend"}, bus.pend, 0);
    check({pfx, "_ovf"},  bus.ovf, 0);
    check({pfx, "_cnt"},  bus.launch_cnt, 0);
    check({pfx, "_tmo"},  bus.tmo_err, 0);
  endtask

  task automatic release_stub();
    busy_cnt      = 0;
    bus.sync_busy = 1'b0;
    stub_auto     = 1'b1;
  endtask

  // launch monitor plus synchronizer busy stub
  always @(negedge clk_a) begin
    if (bus.sync_sig_a) begin
      check("sig_a_single", prev_sig, 0);
      if (sb.size() == 0) begin
        check("unexp_launch", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("tag", bus.tag, mon_e.tag);
        check("launch_cnt", bus.launch_cnt,
              mon_e.cnt);
      end
    end
    prev_sig = bus.sync_sig_a;
    if (stub_auto) begin
      if (bus.sync_sig_a) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0) busy_cnt--;
      bus.sync_busy = (busy_cnt > 0);
    end
  end

  initial begin
    int k;
    bus.req       = '0;
    bus.ovf_clr   = 1'b0;
    bus.sync_busy = 1'b0;
    rst_n         = 1'b0;
    tick(2);
    chk_zero("rst");
    rst_n = 1'b1;

    // single launch
    tick();
    bus.req = 4'b0100;
    expect_launch(2);
    tick();
    bus.req = '0;
    check("t1_pend", bus.pend, 4'b0100);
    check("t1_sig0", bus.sync_sig_a, 0);
    tick();
    check("t1_sig", bus.sync_sig_a, 1);
    check("t1_tag", bus.tag, 2);
    check("t1_cnt", bus.launch_cnt, 1);
    check("t1_pclr", bus.pend, 0);
    tick();
    check("t1_siglo", bus.sync_sig_a, 0);
    drain(50);

    // round-robin from reset
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) expect_launch(i);
    tick();
    bus.req = '0;
    drain(200);
    check("t2_cnt", bus.launch_cnt, 4);
    check("t2_tag", bus.tag, 3);

    // overflow while synchronizer busy
    stub_auto     = 1'b0;
    bus.sync_busy = 1'b1;
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    check("t3_pend", bus.pend, 4'b0010);
    check("t3_ovf", bus.ovf, 4'b0010);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t3_clr", bus.ovf, 0);
    bus.req     = 4'b0010;
    bus.ovf_clr = 1'b1;
    tick();
    bus.req     = '0;
    bus.ovf_clr = 1'b0;
    check("t3_setwin", bus.ovf, 4'b0010);
    check("t3_pend2", bus.pend, 4'b0010);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t3_clr2", bus.ovf, 0);
    check("t3_nolaunch", bus.sync_sig_a, 0);
    expect_launch(1);
    release_stub();
    drain(50);

    // re-request in the grant cycle
    bus.req = 4'b0001;
    expect_launch(0);
    expect_launch(0);
    tick(2);
    bus.req = '0;
    check("t4_sig", bus.sync_sig_a, 1);
    check("t4_pend", bus.pend, 4'b0001);
    check("t4_ovf", bus.ovf, 0);
    drain(100);
    check("t4_pend_end", bus.pend, 0);

    // reset in the middle of a handshake
    stub_auto     = 1'b0;
    bus.sync_busy = 1'b0;
    expect_launch(2);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    k = 0;
    while (!bus.sync_sig_a && k < 10) begin
      tick();
      k++;
    end
    check("t5_seen", bus.sync_sig_a, 1);
    bus.sync_busy = 1'b1;
    bus.req       = 4'b1000;
    tick();
    bus.req = '0;
    tick(2);
    rst_n = 1'b0;
    tick();
    chk_zero("t5_rst");
    rst_n   = 1'b1;
    exp_cnt = 0;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick(5);
    check("t5_hold_pend", bus.pend, 4'b0001);
    check("t5_hold_cnt", bus.launch_cnt, 0);
    expect_launch(0);
    release_stub();
    drain(50);
    check("t5_cnt", bus.launch_cnt, 1);
    check("t5_tag", bus.tag, 0);

`ifdef HSA_TIMEOUT_EN
    // watchdog with busy never rising
    stub_auto     = 1'b0;
    bus.sync_busy = 1'b0;
    expect_launch(2);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    k = 0;
    while (!bus.sync_sig_a && k < 10) begin
      tick();
      k++;
    end
    tick(15);
    check("wd_early", bus.tmo_err, 0);
    tick();
    check("wd_err", bus.tmo_err, 1);
    release_stub();
    drain(50);
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hdshk_sync_arbiter.md
# hdshk_sync_arbiter

Source-domain controller that shares one handshake pulse synchronizer (the `hdshk_pulse_sync` instance) among `N_REQ` requesters, all in the `clk_a` domain. Each requester posts single-cycle event pulses, which the block latches as pending. It grants one event at a time round-robin: it drives the synchronizer's `sig_a` with a one-cycle pulse and presents a stable channel tag, then walks the synchronizer's `busy` handshake before the next launch. It also reports per-requester overflow and a wrapping launch count.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..16.
- `CNT_W`, default 8: width of `launch_cnt`.
- `TIMEOUT_CYC`, default 64: watchdog limit in cycles; used only with `HSA_TIMEOUT_EN`.
- `ID_W`: localparam, $clog2(N_REQ).
- `clk_a`  in  1: sole clock, source domain of the synchronizer.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req`  in  N_REQ: per-requester event pulse, sampled every edge.
- `ovf_clr`  in  1: clears all `ovf` bits.
- `sync_busy`  in  1: `busy` output of the synchronizer.
- `sync_sig_a`  out  1: to the synchronizer `sig_a`; registered one-cycle pulse.
- `tag`  out  ID_W: index of the requester most recently launched.
- `pend`  out  N_REQ: latched pending events.
- `ovf`  out  N_REQ: sticky flags, set when an event is lost.
- `launch_cnt`  out  CNT_W: number of launches, wraps modulo 2^CNT_W.
- `tmo_err`  out  1: sticky watchdog error; tied 0 without `HSA_TIMEOUT_EN`.

## Operation
- **States:** IDLE, WAIT_BUSY, WAIT_DONE.
- **Pending capture:** `req[i]`=1 sets `pend[i]` at the next edge.
  - If `pend[i]` is already 1 and is not being granted that cycle, the event is dropped and `ovf[i]` is set.
  - If `req[i]` arrives in the same cycle that `pend[i]` is granted, `pend[i]` stays 1: set wins over clear, and no overflow is flagged.
- **IDLE:** if `pend`≠0 and `sync_busy`=0, select winner g by round-robin, searching from pointer+1 upward with wrap. At that edge:
  - `sync_sig_a`←1
  - `tag`←g
  - `pend[g]` cleared
  - pointer←g
  - `launch_cnt`+1
  - state←WAIT_BUSY
- If `sync_busy`=1 while in IDLE (synchronizer still draining after a controller reset), no launch occurs.
- **WAIT_BUSY:** `sync_sig_a`←0. Move to WAIT_DONE when `sync_busy`=1.
- **WAIT_DONE:** return to IDLE when `sync_busy`=0.
- **tag:** stable from the launch edge until the next launch edge.
- **ovf_clr:** clears all `ovf` bits. A concurrent overflow on bit i sets `ovf[i]`; set wins.
- **Reset** (`rst_n`=0 at an edge, including mid-handshake): state IDLE; `sync_sig_a`, `pend`, `ovf`, `tag`, `launch_cnt`, `tmo_err` all 0; pointer=N_REQ-1, so requester 0 has first priority.

## Timing
- Latency from `req[i]` to `sync_sig_a`:
  - `req[i]` high in cycle 0.
  - `pend[i]`=1 in cycle 1.
  - `sync_sig_a`=1 in cycle 2, provided the block is IDLE with `sync_busy`=0.
- `sync_sig_a` is never high for two consecutive cycles.
- `sync_busy` is expected to rise 1 cycle after the `sync_sig_a` pulse. WAIT_BUSY tolerates any delay.
- Launch spacing: the earliest next launch is the cycle after the one in which `sync_busy` is sampled 0 in WAIT_DONE, followed by one IDLE decision cycle.
- The outputs `pend`, `ovf`, `tag` and `launch_cnt` are all registered.

## Configuration
- Macro: `HSA_TIMEOUT_EN`.
- **Defined:** a cycle counter runs in WAIT_BUSY and WAIT_DONE and is cleared on entry to WAIT_BUSY. When it reaches `TIMEOUT_CYC`:
  - `tmo_err`←1 (sticky until reset)
  - state←IDLE
  - the pending event is not restored.
- **Undefined:** no counter; `tmo_err` is constant 0; the block waits indefinitely in WAIT_BUSY and WAIT_DONE.

## Structure
- Package `hsa_pkg` holds:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE), 2-bit encoding;
  - the default constants for `N_REQ`, `CNT_W` and `TIMEOUT_CYC`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: grant index, valid.
  - Pointer storage lives in the parent.

## Test plan
- **Single launch:** reset, then `req`=4'b0100 for one cycle.
  - `pend[2]`=1 in cycle 1; `sync_sig_a`=1 in cycle 2 only; `tag`=2; `launch_cnt`=1.
  - With a real `hdshk_pulse_sync`, exactly one `sig_b` pulse appears.
- **Round-robin:** `req`=4'b1111 in one cycle.
  - Launch order by `tag`: 0, 1, 2, 3.
  - Each launch waits for `sync_busy` to fall; `launch_cnt`=4.
- **Overflow:** `req[1]` pulsed twice while `sync_busy` is held 1 from a stub.
  - `ovf[1]`=1 and `pend[1]`=1.
  - An `ovf_clr` pulse clears `ovf[1]`.
- **Simultaneous grant and re-request:** `req[0]` is re-asserted in the launch cycle of 0.
  - `pend[0]` stays 1; `ovf[0]`=0; 0 relaunches later.
- **Reset mid-handshake:** `rst_n`=0 during WAIT_DONE.
  - All outputs are 0.
  - With `sync_busy` still 1, there is no launch until it falls.
- **Watchdog** (`HSA_TIMEOUT_EN`, `TIMEOUT_CYC`=16): stub holds `sync_busy`=0 after the launch.
  - `tmo_err`=1 sixteen cycles after entering WAIT_BUSY; state returns to IDLE.
